kronos_xif_ctrl: RTL and testbench

Offload controller that sits between the CV32E40PX core-v-xif coprocessor interface and the `kronos` datapath. It decodes offloaded instructions, accepts or rejects them, waits for commit and latches operands. It sequences `kronos` through `rol32_1` (single-cycle) or `rol32_2` (register-then-read) and returns the result on the xif result channel. Only one instruction is in flight at a time.

---
 rtl/kronos_pkg.sv | 34 +++
 rtl/kronos_xif_ctrl_if.sv | 40 ++++
 rtl/kronos_xif_decoder.sv | 27 ++
 rtl/kronos_xif_ctrl.sv | 118 +++++++++++
 tb/tb_kronos_xif_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/kronos_pkg.sv
// Shared types and encodings for the kronos datapath and its core-v-xif offload controller.
package kronos_pkg;

  localparam logic [6:0] KRONOS_OPCODE     = 7'b0001011;
  localparam logic [1:0] KRONOS_F2         = 2'b00;
  localparam logic [2:0] KRONOS_F3_ROL32_1 = 3'b000;
  localparam logic [2:0] KRONOS_F3_ROL32_2 = 3'b001;

  typedef enum logic [1:0] {
    nada    = 2'd0,
    rol32_1 = 2'd1,
    rol32_2 = 2'd2
  } kronos_insn;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
  } in_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
  } out_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_COMMIT = 3'd1,
    EXEC        = 3'd2,
    EXEC2       = 3'd3,
    RESP        = 3'd4
  } kronos_ctrl_state_e;

endpackage

// File: rtl/kronos_xif_ctrl_if.sv
// core-v-xif issue/commit/result channels as seen by the kronos offload controller.
interface kronos_xif_ctrl_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [31:0]           issue_instr_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic [2:0][31:0]      issue_rs_i;
  logic [2:0]            issue_rs_valid_i;
  logic                  issue_accept_o;
  logic                  issue_writeback_o;

  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;

  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [X_ID_WIDTH-1:0] result_id_o;
  logic [31:0]           result_data_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;

  // Controller side.
  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  // Core side.
  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
    output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/kronos_xif_decoder.sv
// Combinational decode of an offloaded instruction word into a kronos op.
module kronos_xif_decoder
  import kronos_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_hit,
  output kronos_insn  o_insn,
  output logic [4:0]  o_rd
);

  logic w_unused;
  assign w_unused = ^{i_instr[31:27], i_instr[24:15]};

  always_comb begin
    o_hit  = 1'b0;
    o_insn = nada;
    o_rd   = i_instr[11:7];
    if (i_instr[6:0] == KRONOS_OPCODE && i_instr[26:25] == KRONOS_F2) begin
      case (i_instr[14:12])
        KRONOS_F3_ROL32_1: begin o_hit = 1'b1; o_insn = rol32_1; end
        KRONOS_F3_ROL32_2: begin o_hit = 1'b1; o_insn = rol32_2; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/kronos_xif_ctrl.sv
// Single-outstanding offload controller: issue/commit on xif, sequence kronos, return result.
module kronos_xif_ctrl
  import kronos_pkg::*;
#(
  parameter int X_ID_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  kronos_xif_ctrl_if.slave        xif,
  output in_t                     rs_values_o,
  output kronos_insn              insn_o,
  output logic                    result_reg_en_o,
  input  out_t                    rd_values_i
);

  kronos_ctrl_state_e    r_state, w_state_nxt;
  logic [X_ID_WIDTH-1:0] r_id;
  in_t                   r_rs;
  logic [4:0]            r_rd;
  kronos_insn            r_op;
  logic [31:0]           r_data;

  logic       w_hit, w_latch, w_capture;
  kronos_insn w_insn;
  logic [4:0] w_rd;
  logic       w_unused_rd2;

  assign w_unused_rd2 = ^rd_values_i.rd2;

  kronos_xif_decoder u_dec (
    .i_instr (xif.issue_instr_i),
    .o_hit   (w_hit),
    .o_insn  (w_insn),
    .o_rd    (w_rd)
  );

  always_comb begin
    w_state_nxt           = r_state;
    w_latch               = 1'b0;
    w_capture             = 1'b0;
    xif.issue_ready_o     = 1'b0;
    xif.issue_accept_o    = 1'b0;
    xif.issue_writeback_o = 1'b0;
    xif.result_valid_o    = 1'b0;
    xif.result_we_o       = 1'b0;
    insn_o                = nada;
    result_reg_en_o       = 1'b0;
    case (r_state)
      IDLE: begin
        // Misses are always taken (and rejected); hits wait for all operands.
        xif.issue_ready_o = !w_hit || (&xif.issue_rs_valid_i);
        if (xif.issue_valid_i && xif.issue_ready_o && w_hit) begin
          xif.issue_accept_o    = 1'b1;
          xif.issue_writeback_o = 1'b1;
          w_latch               = 1'b1;
          if (xif.commit_valid_i && xif.commit_id_i == xif.issue_id_i)
            w_state_nxt = xif.commit_kill_i ? IDLE : EXEC;
          else
            w_state_nxt = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (xif.commit_valid_i && xif.commit_id_i == r_id)
          w_state_nxt = xif.commit_kill_i ? IDLE : EXEC;
      end
      EXEC: begin
        if (r_op == rol32_2) begin
          // Two-step op: load kronos' internal register first, read it in EXEC2.
          result_reg_en_o = 1'b1;
          w_state_nxt     = EXEC2;
        end else begin
          insn_o      = rol32_1;
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      EXEC2: begin
        insn_o      = rol32_2;
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        xif.result_valid_o = 1'b1;
        xif.result_we_o    = 1'b1;
        if (xif.result_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_rs    <= '0;
      r_rd    <= '0;
      r_op    <= nada;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_id     <= xif.issue_id_i;
        r_rs.rs1 <= xif.issue_rs_i[0];
        r_rs.rs2 <= xif.issue_rs_i[1];
        r_rs.rs3 <= xif.issue_rs_i[2];
        r_rd     <= w_rd;
        r_op     <= w_insn;
      end
      if (w_capture) r_data <= rd_values_i.rd1;
    end
  end

  assign rs_values_o       = r_rs;
  assign xif.result_id_o   = r_id;
  assign xif.result_data_o = r_data;
  assign xif.result_rd_o   = r_rd;

endmodule

// File: tb/tb_kronos_xif_ctrl.sv
// Directed bench for kronos_xif_ctrl: vector table for single transactions, plus kill/backpressure/reset sequences.
module tb_kronos_xif_ctrl;
  import kronos_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kronos_xif_ctrl_if #(.X_ID_WIDTH(4)) xif();
  in_t        rs_values;
  kronos_insn insn;
  logic       reg_en;
  out_t       rd_values;

  // kronos stub: a distinct rd1 per selected op so routing errors show up in the data.
  always_comb begin
    rd_values = '{rd1: 32'hDEADDEAD, rd2: 32'h0};
    case (insn)
      rol32_1: rd_values.rd1 = 32'hCAFEBABE;
      rol32_2: rd_values.rd1 = 32'h0BADF00D;
      default: ;
    endcase
  end

  kronos_xif_ctrl #(.X_ID_WIDTH(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .xif             (xif),
    .rs_values_o     (rs_values),
    .insn_o          (insn),
    .result_reg_en_o (reg_en),
    .rd_values_i     (rd_values)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    xif.issue_valid_i    = 1'b0;
    xif.issue_instr_i    = 32'h0;
    xif.issue_id_i       = 4'h0;
    xif.issue_rs_i       = '0;
    xif.issue_rs_valid_i = 3'b000;
    xif.commit_valid_i   = 1'b0;
    xif.commit_id_i      = 4'h0;
    xif.commit_kill_i    = 1'b0;
    xif.result_ready_i   = 1'b1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [2:0] rsv,
                       input logic cv, input logic kill);
    xif.issue_valid_i    = 1'b1;
    xif.issue_instr_i    = instr;
    xif.issue_id_i       = id;
    xif.issue_rs_i       = {32'h00000008, 32'h9ABCDEF0, 32'h12345678};
    xif.issue_rs_valid_i = rsv;
    xif.commit_valid_i   = cv;
    xif.commit_id_i      = id;
    xif.commit_kill_i    = kill;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [1:0] f2,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {5'd0, f2, 10'd0, f3, rd, op};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  id;
    logic [2:0]  rsv;
    logic        acc;
    logic        rdy;
    kronos_insn  op;
    int          lat;
    logic [31:0] data;
    logic [4:0]  rd;
  } vec_t;

  vec_t v[7];

  initial begin
    int lat;
    logic [31:0] exp_insn;

    v[0] = '{mk(7'b0001011, 2'b00, 3'b000, 5'd5),  4'd3,  3'b111, 1'b1, 1'b1, rol32_1, 2, 32'hCAFEBABE, 5'd5};
    v[1] = '{mk(7'b0001011, 2'b00, 3'b001, 5'd9),  4'd3,  3'b111, 1'b1, 1'b1, rol32_2, 3, 32'h0BADF00D, 5'd9};
    v[2] = '{mk(7'b0001011, 2'b00, 3'b010, 5'd4),  4'd4,  3'b111, 1'b0, 1'b1, nada,    0, 32'h0,        5'd0};
    v[3] = '{mk(7'b0110011, 2'b00, 3'b000, 5'd4),  4'd4,  3'b000, 1'b0, 1'b1, nada,    0, 32'h0,        5'd0};
    v[4] = '{mk(7'b0001011, 2'b01, 3'b000, 5'd4),  4'd4,  3'b111, 1'b0, 1'b1, nada,    0, 32'h0,        5'd0};
    v[5] = '{mk(7'b0001011, 2'b00, 3'b000, 5'd4),  4'd4,  3'b011, 1'b0, 1'b0, nada,    0, 32'h0,        5'd0};
    v[6] = '{mk(7'b0001011, 2'b00, 3'b001, 5'd31), 4'd15, 3'b111, 1'b1, 1'b1, rol32_2, 3, 32'h0BADF00D, 5'd31};

    // Reset state
    idle_in();
    rst_n = 1'b0;
    step();
    samp();
    chk("rst_ready",  32'(xif.issue_ready_o),  32'd1);
    chk("rst_accept", 32'(xif.issue_accept_o), 32'd0);
    chk("rst_valid",  32'(xif.result_valid_o), 32'd0);
    chk("rst_we",     32'(xif.result_we_o),    32'd0);
    chk("rst_insn",   32'(insn),               32'(nada));
    chk("rst_regen",  32'(reg_en),             32'd0);
    chk("rst_rs1",    rs_values.rs1,           32'd0);
    chk("rst_data",   xif.result_data_o,       32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single-transaction vectors, commit in the issue cycle
    for (int i = 0; i < 7; i++) begin
      issue(v[i].instr, v[i].id, v[i].rsv, 1'b1, 1'b0);
      samp();
      chk($sformatf("v%0d_ready", i),  32'(xif.issue_ready_o),     32'(v[i].rdy));
      chk($sformatf("v%0d_accept", i), 32'(xif.issue_accept_o),    32'(v[i].acc));
      chk($sformatf("v%0d_wb", i),     32'(xif.issue_writeback_o), 32'(v[i].acc));
      step();
      idle_in();
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
        samp();
        if (c == 1) begin
          exp_insn = (v[i].acc && v[i].op == rol32_1) ? 32'(rol32_1) : 32'(nada);
          chk($sformatf("v%0d_insn1", i),  32'(insn),   exp_insn);
          chk($sformatf("v%0d_regen1", i), 32'(reg_en), 32'(v[i].acc && v[i].op == rol32_2));
          if (v[i].acc) begin
            chk($sformatf("v%0d_rs1", i), rs_values.rs1, 32'h12345678);
            chk($sformatf("v%0d_rs3", i), rs_values.rs3, 32'h00000008);
          end
        end
        if (c == 2 && v[i].acc && v[i].op == rol32_2) begin
          chk($sformatf("v%0d_insn2", i),  32'(insn),   32'(rol32_2));
          chk($sformatf("v%0d_regen2", i), 32'(reg_en), 32'd0);
        end
        if (xif.result_valid_o && lat == 0) begin
          lat = c;
          chk($sformatf("v%0d_data", i), xif.result_data_o,   v[i].data);
          chk($sformatf("v%0d_id", i),   32'(xif.result_id_o), 32'(v[i].id));
          chk($sformatf("v%0d_rd", i),   32'(xif.result_rd_o), 32'(v[i].rd));
          chk($sformatf("v%0d_we", i),   32'(xif.result_we_o), 32'd1);
        end
        step();
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
    end

    // Kill after delayed commit, then immediate re-issue
    issue(mk(7'b0001011, 2'b00, 3'b000, 5'd3), 4'd5, 3'b111, 1'b0, 1'b0);
    samp();
    chk("kill_accept", 32'(xif.issue_accept_o), 32'd1);
    step();
    idle_in();
    for (int c = 0; c < 3; c++) begin
      samp();
      chk("kill_wait_ready", 32'(xif.issue_ready_o),  32'd0);
      chk("kill_wait_valid", 32'(xif.result_valid_o), 32'd0);
      step();
    end
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd5;
    xif.commit_kill_i  = 1'b1;
    samp();
    step();
    idle_in();
    issue(mk(7'b0001011, 2'b00, 3'b000, 5'd12), 4'd6, 3'b111, 1'b1, 1'b0);
    samp();
    chk("kill_reissue_ready",  32'(xif.issue_ready_o),  32'd1);
    chk("kill_reissue_accept", 32'(xif.issue_accept_o), 32'd1);
    chk("kill_no_result",      32'(xif.result_valid_o), 32'd0);
    step();
    idle_in();
    samp();
    chk("kill_exec_valid", 32'(xif.result_valid_o), 32'd0);
    step();
    samp();
    chk("reissue_valid", 32'(xif.result_valid_o), 32'd1);
    chk("reissue_id",    32'(xif.result_id_o),    32'd6);
    chk("reissue_data",  xif.result_data_o,       32'hCAFEBABE);
    step();

    // Foreign commit ignored, then backpressure on the result
    issue(mk(7'b0001011, 2'b00, 3'b000, 5'd7), 4'd1, 3'b111, 1'b0, 1'b0);
    samp();
    chk("bp_accept", 32'(xif.issue_accept_o), 32'd1);
    step();
    idle_in();
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd2;
    samp();
    step();
    idle_in();
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd1;
    samp();
    chk("bp_foreign_ready", 32'(xif.issue_ready_o), 32'd0);
    chk("bp_foreign_insn",  32'(insn),              32'(nada));
    step();
    idle_in();
    xif.result_ready_i = 1'b0;
    samp();
    chk("bp_exec_insn", 32'(insn), 32'(rol32_1));
    step();
    for (int c = 0; c < 4; c++) begin
      samp();
      chk("bp_hold_valid", 32'(xif.result_valid_o), 32'd1);
      chk("bp_hold_data",  xif.result_data_o,       32'hCAFEBABE);
      chk("bp_hold_rd",    32'(xif.result_rd_o),    32'd7);
      chk("bp_hold_id",    32'(xif.result_id_o),    32'd1);
      step();
    end
    xif.result_ready_i = 1'b1;
    samp();
    chk("bp_release_valid", 32'(xif.result_valid_o), 32'd1);
    step();
    samp();
    chk("bp_after_valid", 32'(xif.result_valid_o), 32'd0);
    chk("bp_after_ready", 32'(xif.issue_ready_o),  32'd1);
    step();

    // Asynchronous reset while in EXEC2
    issue(mk(7'b0001011, 2'b00, 3'b001, 5'd2), 4'd9, 3'b111, 1'b1, 1'b0);
    samp();
    chk("rstmid_accept", 32'(xif.issue_accept_o), 32'd1);
    step();
    idle_in();
    samp();
    chk("rstmid_regen", 32'(reg_en), 32'd1);
    step();
    samp();
    chk("rstmid_insn2", 32'(insn), 32'(rol32_2));
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_insn",  32'(insn),               32'(nada));
    chk("rstmid_regen0", 32'(reg_en),            32'd0);
    chk("rstmid_valid", 32'(xif.result_valid_o), 32'd0);
    chk("rstmid_ready", 32'(xif.issue_ready_o),  32'd1);
    chk("rstmid_rs1",   rs_values.rs1,           32'd0);
    chk("rstmid_data",  xif.result_data_o,       32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      samp();
      chk("rstmid_no_result", 32'(xif.result_valid_o), 32'd0);
      chk("rstmid_no_kronos", 32'(insn),               32'(nada));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
